// File: rtl/ttc_pkg.sv
// Shared types and constants for the TTC restart scheduler.
// Holds the FSM state encoding and the width constants for channel index and hold counter.
package ttc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } rs_state_e;

  localparam int TTC_NUM_CH_MAX = 8;
  localparam int TTC_HOLD_W     = 4;
  localparam int TTC_IDX_W      = $clog2(TTC_NUM_CH_MAX);

endpackage

// File: rtl/ttc_restart_sched_if.sv
// Channel-side signal bundle of the TTC restart scheduler.
// The master modport is the request/feedback side; the slave modport is the scheduler.
interface ttc_restart_sched_if #(
  parameter int NUM_CH = 3
);

  logic [NUM_CH-1:0] restart_req;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] count_en_in;
  logic [NUM_CH-1:0] err_clr;
  logic [NUM_CH-1:0] restart_out;
  logic [NUM_CH-1:0] done_pulse;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ack_err;
  logic              busy;

  modport master (
    output restart_req, ch_enable, count_en_in, err_clr,
    input  restart_out, done_pulse, pending, ack_err, busy
  );

  modport slave (
    input  restart_req, ch_enable, count_en_in, err_clr,
    output restart_out, done_pulse, pending, ack_err, busy
  );

endinterface

// File: rtl/ttc_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to bit 0.
// Returns the winner both one-hot and as an index; any flags a non-empty request vector.
module ttc_rr_pick
  import ttc_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0]    req,
  input  logic [TTC_IDX_W-1:0] ptr,
  output logic [NUM_CH-1:0]    grant_oh,
  output logic [TTC_IDX_W-1:0] grant_idx,
  output logic                 any
);

  logic [NUM_CH-1:0] hi_mask;
  logic [NUM_CH-1:0] sel;

  // Prefer requests at or above the pointer; fall back to the full vector to wrap around.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hi_mask[i] = (TTC_IDX_W'(i) >= ptr);
    end
    sel = (|(req & hi_mask)) ? (req & hi_mask) : req;

    grant_oh  = '0;
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sel[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_idx   = TTC_IDX_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ttc_restart_sched.sv
// Round-robin restart scheduler for TTC channels: hold restart, release, then strobe done.
// Optional enable-drop checking is built only when TTC_RSCHED_ACKCHK_EN is defined.
module ttc_restart_sched
  import ttc_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int HOLD_CYC = 2
) (
  input  logic              pclk12,
  input  logic              n_p_reset12,
  ttc_restart_sched_if.slave bus
);

  localparam logic [TTC_IDX_W-1:0]  LAST_IDX  = TTC_IDX_W'(NUM_CH - 1);
  localparam logic [TTC_HOLD_W-1:0] HOLD_LAST = TTC_HOLD_W'(HOLD_CYC - 1);

  rs_state_e               state_q, state_n;
  logic [TTC_HOLD_W-1:0]   hold_q, hold_n;
  logic [TTC_IDX_W-1:0]    rr_q, rr_n;
  logic [NUM_CH-1:0]       grant_oh_q, grant_oh_n;
  logic [NUM_CH-1:0]       pending_q, pending_n;
  logic [NUM_CH-1:0]       rst_out_q, rst_out_n;
  logic [NUM_CH-1:0]       done_q, done_n;
  logic [NUM_CH-1:0]       served;
  logic                    assert_exit;

  logic [NUM_CH-1:0]       pick_oh;
  logic [TTC_IDX_W-1:0]    pick_idx;
  logic                    pick_any;

  // A channel whose enable has just dropped must not win even if its pending bit is still set.
  ttc_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req       (pending_q & bus.ch_enable),
    .ptr       (rr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_ff @(posedge pclk12 or negedge n_p_reset12) begin
    if (!n_p_reset12) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rr_q       <= '0;
      grant_oh_q <= '0;
      pending_q  <= '0;
      rst_out_q  <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_n;
      hold_q     <= hold_n;
      rr_q       <= rr_n;
      grant_oh_q <= grant_oh_n;
      pending_q  <= pending_n;
      rst_out_q  <= rst_out_n;
      done_q     <= done_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    hold_n      = hold_q;
    rr_n        = rr_q;
    grant_oh_n  = grant_oh_q;
    rst_out_n   = '0;
    done_n      = '0;
    served      = '0;
    assert_exit = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          served     = pick_oh;
          grant_oh_n = pick_oh;
          rr_n       = (pick_idx == LAST_IDX) ? '0 : pick_idx + TTC_IDX_W'(1);
          hold_n     = '0;
          rst_out_n  = pick_oh;
          state_n    = ASSERT;
        end
      end
      ASSERT: begin
        if (hold_q == HOLD_LAST) begin
          assert_exit = 1'b1;
          state_n     = RELEASE;
        end else begin
          hold_n    = hold_q + TTC_HOLD_W'(1);
          rst_out_n = grant_oh_q;
        end
      end
      RELEASE: begin
        done_n  = grant_oh_q;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A same-cycle request on the served channel survives the clear and is served again later.
    pending_n = ((pending_q & ~served) | bus.restart_req) & bus.ch_enable;
  end

  assign bus.restart_out = rst_out_q;
  assign bus.done_pulse  = done_q;
  assign bus.pending     = pending_q;
  assign bus.busy        = (state_q != IDLE);

`ifdef TTC_RSCHED_ACKCHK_EN
  logic              seen_low_q;
  logic              seen_cur;
  logic [NUM_CH-1:0] ack_err_q;

  assign seen_cur = seen_low_q | ~|(bus.count_en_in & grant_oh_q);

  // Error set at ASSERT exit takes priority over a same-cycle clear.
  always_ff @(posedge pclk12 or negedge n_p_reset12) begin
    if (!n_p_reset12) begin
      seen_low_q <= 1'b0;
      ack_err_q  <= '0;
    end else begin
      if (state_q == IDLE)        seen_low_q <= 1'b0;
      else if (state_q == ASSERT) seen_low_q <= seen_cur;
      ack_err_q <= (ack_err_q & ~bus.err_clr) |
                   ((assert_exit && !seen_cur) ? grant_oh_q : '0);
    end
  end

  assign bus.ack_err = ack_err_q;
`else
  logic unused_ackchk;
  assign unused_ackchk = ^{bus.count_en_in, bus.err_clr, assert_exit};
  assign bus.ack_err   = '0;
`endif

endmodule

// File: tb/tb_ttc_restart_sched.sv
// Self-checking bench for ttc_restart_sched (NUM_CH=3, HOLD_CYC=2); done order is scoreboarded.
module tb_ttc_restart_sched;

  logic pclk12 = 1'b0;
  logic n_p_reset12;
  always #5 pclk12 = ~pclk12;

  ttc_restart_sched_if #(.NUM_CH(3)) bus ();

  ttc_restart_sched #(.NUM_CH(3), .HOLD_CYC(2)) dut (
    .pclk12      (pclk12),
    .n_p_reset12 (n_p_reset12),
    .bus         (bus)
  );

  typedef struct {
    logic [2:0] req;
    logic [2:0] exp_rst;
    logic [2:0] exp_done;
    logic       exp_busy;
    logic [2:0] exp_pend;
  } vec_t;

  vec_t tbl [6];
  int   checks   = 0;
  int   failures = 0;
  int   sb_q [$];

  task automatic tick();
    @(posedge pclk12);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((bus.busy || bus.pending != 3'b000 || sb_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s timeout after %0d cycles busy=%b pending=%b queued=%0d",
               name, n, bus.busy, bus.pending, sb_q.size());
    end
  endtask

  // Completion scoreboard: each done strobe must match the next expected channel.
  always @(negedge pclk12) begin
    if (n_p_reset12 && bus.done_pulse != 3'b000) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL done_order actual=%b required=none", bus.done_pulse);
      end else begin
        int         e;
        logic [2:0] m;
        e = sb_q.pop_front();
        m = 3'b001 << e;
        if (bus.done_pulse !== m) begin
          failures++;
          $display("FAIL done_order actual=%b required=%b", bus.done_pulse, m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_ack;
    tbl[0] = '{3'b001, 3'b000, 3'b000, 1'b0, 3'b001};
    tbl[1] = '{3'b000, 3'b001, 3'b000, 1'b1, 3'b000};
    tbl[2] = '{3'b000, 3'b001, 3'b000, 1'b1, 3'b000};
    tbl[3] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'b000};
    tbl[4] = '{3'b000, 3'b000, 3'b001, 1'b1, 3'b000};
    tbl[5] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000};

    n_p_reset12     = 1'b0;
    bus.restart_req = 3'b000;
    bus.ch_enable   = 3'b111;
    bus.count_en_in = 3'b111;
    bus.err_clr     = 3'b000;
    repeat (2) @(posedge pclk12);
    #1;
    chk("reset_outputs", bus.restart_out | bus.done_pulse | bus.pending | bus.ack_err |
        {2'b00, bus.busy}, 3'b000);
    n_p_reset12 = 1'b1;
    tick();

    // Single ch0 request, cycle-accurate latency
    sb_q.push_back(0);
    for (int i = 0; i < 6; i++) begin
      bus.restart_req = tbl[i].req;
      tick();
      chk($sformatf("single_rst_r%0d", i), bus.restart_out, tbl[i].exp_rst);
      chk($sformatf("single_done_r%0d", i), bus.done_pulse, tbl[i].exp_done);
      chk($sformatf("single_busy_r%0d", i), {2'b00, bus.busy}, {2'b00, tbl[i].exp_busy});
      chk($sformatf("single_pend_r%0d", i), bus.pending, tbl[i].exp_pend);
    end
    bus.restart_req = 3'b000;

    // Asynchronous reset in the middle of ch1's ASSERT
    bus.restart_req = 3'b010;
    tick();
    bus.restart_req = 3'b000;
    tick();
    chk("midassert_rst_out", bus.restart_out, 3'b010);
    #2 n_p_reset12 = 1'b0;
    #1;
    chk("async_reset_outputs", bus.restart_out | bus.done_pulse | bus.pending | bus.ack_err |
        {2'b00, bus.busy}, 3'b000);
    @(posedge pclk12);
    #2 n_p_reset12 = 1'b1;
    tick();
    chk("post_reset_idle", {2'b00, bus.busy} | bus.pending, 3'b000);

    // Simultaneous requests from rr_ptr=0: ch0, ch1, ch2, five cycles apart
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
    bus.restart_req = 3'b111;
    tick();
    bus.restart_req = 3'b000;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) repeat (5) tick();
      chk($sformatf("rr0_grant%0d", k), bus.restart_out, 3'b001 << k);
    end
    wait_idle("rr0_drain", 40);

    // Move rr_ptr to 2, then simultaneous requests: ch2, ch0, ch1
    sb_q.push_back(1);
    bus.restart_req = 3'b010;
    tick();
    bus.restart_req = 3'b000;
    wait_idle("rr_setup", 20);
    sb_q.push_back(2); sb_q.push_back(0); sb_q.push_back(1);
    bus.restart_req = 3'b111;
    tick();
    bus.restart_req = 3'b000;
    tick();
    chk("rr2_grant0", bus.restart_out, 3'b100);
    repeat (5) tick();
    chk("rr2_grant1", bus.restart_out, 3'b001);
    repeat (5) tick();
    chk("rr2_grant2", bus.restart_out, 3'b010);
    wait_idle("rr2_drain", 40);

    // Disabled ch1 never captured; ch2 completes although its enable drops mid-service
    bus.ch_enable = 3'b101;
    sb_q.push_back(2); sb_q.push_back(0);
    bus.restart_req = 3'b111;
    tick();
    bus.restart_req = 3'b000;
    chk("en_gate_pending", bus.pending, 3'b101);
    tick();
    chk("en_gate_grant", bus.restart_out, 3'b100);
    tick();
    bus.ch_enable = 3'b001;
    repeat (3) tick();
    chk("en_gate_pending_late", bus.pending, 3'b001);
    wait_idle("en_gate_drain", 30);
    bus.ch_enable = 3'b111;

    // Re-request ch0 during its own ASSERT: served twice
    sb_q.push_back(0); sb_q.push_back(0);
    bus.restart_req = 3'b001;
    tick();
    bus.restart_req = 3'b000;
    tick();
    chk("rereq_cleared", bus.pending, 3'b000);
    chk("rereq_assert", bus.restart_out, 3'b001);
    bus.restart_req = 3'b001;
    tick();
    bus.restart_req = 3'b000;
    chk("rereq_pending", bus.pending, 3'b001);
    wait_idle("rereq_drain", 30);

    // Enable-drop check on ch1: stuck-high feedback flags it, clear, then normal feedback
`ifdef TTC_RSCHED_ACKCHK_EN
    exp_ack = 3'b010;
`else
    exp_ack = 3'b000;
`endif
    sb_q.push_back(1);
    bus.restart_req = 3'b010;
    tick();
    bus.restart_req = 3'b000;
    repeat (3) tick();
    chk("ackerr_set", bus.ack_err, exp_ack);
    wait_idle("ackerr_drain", 20);
    bus.err_clr = 3'b010;
    tick();
    bus.err_clr = 3'b000;
    chk("ackerr_clear", bus.ack_err, 3'b000);
    sb_q.push_back(1);
    bus.restart_req = 3'b010;
    tick();
    bus.restart_req = 3'b000;
    tick();
    bus.count_en_in = 3'b101;
    tick();
    bus.count_en_in = 3'b111;
    wait_idle("acknormal_drain", 20);
    chk("ackerr_normal", bus.ack_err, 3'b000);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
